// File: rtl/hack_cpu.sv
// hack_cpu: single-cycle Hack CPU core plus its combinational ALU.
// Holds A, D and PC; decodes A/C instructions and drives the data-memory port.

module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] w_x;
    logic [15:0] w_y;
    logic [15:0] w_f;

    // Operand preset/negate, add-or-and, optional output negate, status flags
    always_comb begin
        w_x = zx ? '0 : x;
        w_x = nx ? ~w_x : w_x;
        w_y = zy ? '0 : y;
        w_y = ny ? ~w_y : w_y;
        w_f = f ? (w_x + w_y) : (w_x & w_y);
        out = no ? ~w_f : w_f;
        zr  = (out == '0);
        ng  = out[15];
    end

endmodule

module hack_cpu (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] inM,
    input  logic [15:0] instruction,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);

    logic [15:0] r_a;
    logic [15:0] r_d;
    logic [14:0] r_pc;

    logic        w_is_c;
    logic [15:0] w_alu_y;
    logic [15:0] w_alu_out;
    logic        w_zr;
    logic        w_ng;
    logic        w_jump;

    ALU u_alu (
        .x   (r_d),
        .y   (w_alu_y),
        .zx  (instruction[11]),
        .nx  (instruction[10]),
        .zy  (instruction[9]),
        .ny  (instruction[8]),
        .f   (instruction[7]),
        .no  (instruction[6]),
        .out (w_alu_out),
        .zr  (w_zr),
        .ng  (w_ng)
    );

    // Instruction decode: operand select, jump condition, memory-port outputs
    always_comb begin
        w_is_c   = instruction[15];
        w_alu_y  = instruction[12] ? inM : r_a;
        w_jump   = w_is_c & ((instruction[2] & w_ng) |
                             (instruction[1] & w_zr) |
                             (instruction[0] & ~w_ng & ~w_zr));
        outM     = w_alu_out;
        writeM   = w_is_c & instruction[3] & ~reset;
        addressM = r_a[14:0];
        pc       = r_pc;
    end

    // Register update; jump target uses A from before this edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a  <= '0;
            r_d  <= '0;
            r_pc <= '0;
        end else begin
            if (!w_is_c)
                r_a <= instruction;
            else if (instruction[5])
                r_a <= w_alu_out;
            if (w_is_c && instruction[4])
                r_d <= w_alu_out;
            r_pc <= w_jump ? r_a[14:0] : r_pc + 15'd1;
        end
    end

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: table-driven directed test of hack_cpu, one row per cycle.

module tb_hack_cpu;

    logic        clock;
    logic        reset;
    logic [15:0] inM;
    logic [15:0] instruction;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    int checks = 0;
    int errors = 0;

    hack_cpu dut (
        .clock       (clock),
        .reset       (reset),
        .inM         (inM),
        .instruction (instruction),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // care bits: [3]=outM [2]=writeM [1]=addressM [0]=pc
    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic [15:0] m_in;
        logic [3:0]  care;
        logic [15:0] e_out;
        logic        e_wr;
        logic [14:0] e_addr;
        logic [14:0] e_pc;
    } vec_t;

    vec_t vecs[36];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    initial begin
        // Reset state and outM = D readback
        vecs[0]  = '{1'b1, 16'hE308, 16'h0000, 4'b0100, 16'h0000, 1'b0, 15'd0,      15'd0};
        vecs[1]  = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'd0,      15'd0};
        vecs[2]  = '{1'b1, 16'hE308, 16'h0000, 4'b0100, 16'h0000, 1'b0, 15'd0,      15'd0};
        // Add and store
        vecs[3]  = '{1'b0, 16'h0009, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd0,      15'd0};
        vecs[4]  = '{1'b0, 16'hEC10, 16'h0000, 4'b1111, 16'd9,    1'b0, 15'd9,      15'd1};
        vecs[5]  = '{1'b0, 16'h000F, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd9,      15'd2};
        vecs[6]  = '{1'b0, 16'hE090, 16'h0000, 4'b1111, 16'd24,   1'b0, 15'd15,     15'd3};
        vecs[7]  = '{1'b0, 16'h0064, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd15,     15'd4};
        vecs[8]  = '{1'b0, 16'hE308, 16'h0000, 4'b1111, 16'd24,   1'b1, 15'd100,    15'd5};
        // Memory operand and JLT
        vecs[9]  = '{1'b0, 16'hFC10, 16'hFFFB, 4'b1111, 16'hFFFB, 1'b0, 15'd100,    15'd6};
        vecs[10] = '{1'b0, 16'h0014, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd100,    15'd7};
        vecs[11] = '{1'b0, 16'hE304, 16'h0000, 4'b1111, 16'hFFFB, 1'b0, 15'd20,     15'd8};
        vecs[12] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'hFFFB, 1'b0, 15'd20,     15'd20};
        // Zero jumps
        vecs[13] = '{1'b0, 16'hEA90, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'd20,     15'd21};
        vecs[14] = '{1'b0, 16'h0028, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd20,     15'd22};
        vecs[15] = '{1'b0, 16'hE302, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'd40,     15'd23};
        vecs[16] = '{1'b0, 16'hE305, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'd40,     15'd40};
        vecs[17] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'd40,     15'd41};
        // Dest A plus jump uses old A
        vecs[18] = '{1'b0, 16'h0032, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd40,     15'd42};
        vecs[19] = '{1'b0, 16'hEC10, 16'h0000, 4'b1111, 16'd50,   1'b0, 15'd50,     15'd43};
        vecs[20] = '{1'b0, 16'h0005, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd50,     15'd44};
        vecs[21] = '{1'b0, 16'hE327, 16'h0000, 4'b1111, 16'd50,   1'b0, 15'd5,      15'd45};
        vecs[22] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'd50,   1'b0, 15'd50,     15'd5};
        // PC wrap
        vecs[23] = '{1'b0, 16'h7FFF, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'd50,     15'd6};
        vecs[24] = '{1'b0, 16'hEA87, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'h7FFF,   15'd7};
        vecs[25] = '{1'b0, 16'h0001, 16'h0000, 4'b0111, 16'h0000, 1'b0, 15'h7FFF,   15'h7FFF};
        vecs[26] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'd50,   1'b0, 15'd1,      15'd0};
        // Mid-run reset on MD=D: no write, D intact before edge
        vecs[27] = '{1'b1, 16'hE318, 16'h0000, 4'b1111, 16'd50,   1'b0, 15'd1,      15'd1};
        vecs[28] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'h0000, 1'b0, 15'd0,      15'd0};
        // A[15] set by C-instruction; only A[14:0] used
        vecs[29] = '{1'b0, 16'hEE90, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'd0,      15'd1};
        vecs[30] = '{1'b0, 16'hE320, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'd0,      15'd2};
        vecs[31] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'h7FFF,   15'd3};
        vecs[32] = '{1'b0, 16'hE338, 16'h0000, 4'b1111, 16'hFFFF, 1'b1, 15'h7FFF,   15'd4};
        vecs[33] = '{1'b0, 16'hE307, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'h7FFF,   15'd5};
        vecs[34] = '{1'b0, 16'hE300, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'h7FFF,   15'h7FFF};
        // Bits 14:13 ignored
        vecs[35] = '{1'b0, 16'h8300, 16'h0000, 4'b1111, 16'hFFFF, 1'b0, 15'h7FFF,   15'd0};

        reset       = 1'b1;
        instruction = 16'h0000;
        inM         = 16'h0000;

        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            reset       = vecs[i].rst;
            instruction = vecs[i].ins;
            inM         = vecs[i].m_in;
            #2;
            if (vecs[i].care[3]) chk16($sformatf("v%0d outM", i), outM, vecs[i].e_out);
            if (vecs[i].care[2]) chk16($sformatf("v%0d writeM", i), {15'd0, writeM}, {15'd0, vecs[i].e_wr});
            if (vecs[i].care[1]) chk16($sformatf("v%0d addressM", i), {1'b0, addressM}, {1'b0, vecs[i].e_addr});
            if (vecs[i].care[0]) chk16($sformatf("v%0d pc", i), {1'b0, pc}, {1'b0, vecs[i].e_pc});
        end

        // Held reset over several cycles: write stays blocked, state held at 0
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            reset       = 1'b1;
            instruction = 16'hE338;
            #2;
            chk16($sformatf("hold%0d writeM", k), {15'd0, writeM}, 16'd0);
        end
        @(negedge clock);
        reset       = 1'b0;
        instruction = 16'hE308;
        #2;
        chk16("post-hold pc", {1'b0, pc}, 16'd0);
        chk16("post-hold addressM", {1'b0, addressM}, 16'd0);
        chk16("post-hold outM", outM, 16'd0);
        chk16("post-hold writeM", {15'd0, writeM}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
